// File: rtl/dac_spi_receiver.sv
// Receive-side model of the LTC2624 serial interface: oversamples SCK/MOSI/CS/CLR in the
// CLK_50M domain and decodes 32-bit frames into channel A/B input and output registers.
module dac_spi_receiver #(
  parameter int unsigned FRAME_BITS  = 32,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        CLK_50M,
  input  logic        RST,
  input  logic        SPI_SCK,
  input  logic        SPI_MOSI,
  input  logic        DAC_CS,
  input  logic        DAC_CLR,
  output logic [11:0] dac_a,
  output logic [11:0] dac_b,
  output logic [11:0] in_a,
  output logic [11:0] in_b,
  output logic        update,
  output logic [1:0]  upd_chan,
  output logic        frame_err,
  output logic [15:0] frame_cnt
);

  typedef enum logic [1:0] {StIdle, StShift, StDecode} state_e;

  localparam logic [5:0] FrameLen = 6'(FRAME_BITS);

  logic [SYNC_STAGES-1:0] sck_sync_q, mosi_sync_q, cs_sync_q, clr_sync_q;
  logic                   sck_d_q, cs_d_q;
  logic                   sck_s, mosi_s, cs_s, clr_s;
  logic                   sck_rise, cs_fall, cs_rise;

  state_e      state_q;
  logic [31:0] shreg_q;
  logic [5:0]  bit_cnt_q;
  logic [11:0] dac_a_q, dac_b_q, in_a_q, in_b_q;
  logic [11:0] dac_a_d, dac_b_d, in_a_d, in_b_d;
  logic        update_q, frame_err_q;
  logic [1:0]  upd_chan_q;
  logic [15:0] frame_cnt_q;

  logic [3:0]  cmd, addr;
  logic [11:0] data;
  logic        sel_a, sel_b, ld_a, ld_b, dac_changed;
  logic        unused_shreg_msb;

  // Synchronisers load the bus idle levels so reset never fakes a CS or SCK edge.
  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      sck_sync_q  <= '0;
      mosi_sync_q <= '0;
      cs_sync_q   <= '1;
      clr_sync_q  <= '1;
      sck_d_q     <= 1'b0;
      cs_d_q      <= 1'b1;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_STAGES-2:0], SPI_SCK};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], SPI_MOSI};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], DAC_CS};
      clr_sync_q  <= {clr_sync_q[SYNC_STAGES-2:0], DAC_CLR};
      sck_d_q     <= sck_s;
      cs_d_q      <= cs_s;
    end
  end

  assign sck_s    = sck_sync_q[SYNC_STAGES-1];
  assign mosi_s   = mosi_sync_q[SYNC_STAGES-1];
  assign cs_s     = cs_sync_q[SYNC_STAGES-1];
  assign clr_s    = clr_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_d_q;
  assign cs_fall  = ~cs_s & cs_d_q;
  assign cs_rise  = cs_s & ~cs_d_q;

  assign cmd              = shreg_q[23:20];
  assign addr             = shreg_q[19:16];
  assign data             = shreg_q[15:4];
  assign unused_shreg_msb = shreg_q[31];

  always_comb begin
    in_a_d  = in_a_q;
    in_b_d  = in_b_q;
    dac_a_d = dac_a_q;
    dac_b_d = dac_b_q;
    ld_a    = 1'b0;
    ld_b    = 1'b0;
    sel_a   = (addr == 4'h0) || (addr == 4'hF);
    sel_b   = (addr == 4'h1) || (addr == 4'hF);
    if (sel_a || sel_b) begin
      case (cmd)
        4'h0: begin
          if (sel_a) in_a_d = data;
          if (sel_b) in_b_d = data;
        end
        4'h1: begin
          if (sel_a) begin dac_a_d = in_a_q; ld_a = 1'b1; end
          if (sel_b) begin dac_b_d = in_b_q; ld_b = 1'b1; end
        end
        4'h2: begin
          // Write the selected inputs, then update both outputs from the new inputs.
          if (sel_a) in_a_d = data;
          if (sel_b) in_b_d = data;
          dac_a_d = in_a_d;
          dac_b_d = in_b_d;
          ld_a    = 1'b1;
          ld_b    = 1'b1;
        end
        4'h3: begin
          if (sel_a) begin in_a_d = data; dac_a_d = data; ld_a = 1'b1; end
          if (sel_b) begin in_b_d = data; dac_b_d = data; ld_b = 1'b1; end
        end
        default: ;
      endcase
    end
    dac_changed = (dac_a_d != dac_a_q) || (dac_b_d != dac_b_q);
  end

  always_ff @(posedge CLK_50M) begin
    if (RST) begin
      state_q     <= StIdle;
      shreg_q     <= '0;
      bit_cnt_q   <= '0;
      dac_a_q     <= '0;
      dac_b_q     <= '0;
      in_a_q      <= '0;
      in_b_q      <= '0;
      update_q    <= 1'b0;
      upd_chan_q  <= '0;
      frame_err_q <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      update_q    <= 1'b0;
      frame_err_q <= 1'b0;
      if (!clr_s) begin
        // Clear wins over everything, including a pending decode.
        dac_a_q   <= '0;
        dac_b_q   <= '0;
        in_a_q    <= '0;
        in_b_q    <= '0;
        shreg_q   <= '0;
        bit_cnt_q <= '0;
        state_q   <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            if (cs_fall) state_q <= StShift;
          end
          StShift: begin
            if (sck_rise) begin
              shreg_q <= {shreg_q[30:0], mosi_s};
              if (bit_cnt_q != 6'd63) bit_cnt_q <= bit_cnt_q + 6'd1;
            end
            if (cs_rise) state_q <= StDecode;
          end
          StDecode: begin
            if (bit_cnt_q == FrameLen) begin
              in_a_q      <= in_a_d;
              in_b_q      <= in_b_d;
              dac_a_q     <= dac_a_d;
              dac_b_q     <= dac_b_d;
              frame_cnt_q <= frame_cnt_q + 16'd1;
              if (dac_changed) begin
                update_q   <= 1'b1;
                upd_chan_q <= {ld_b, ld_a};
              end
            end else begin
              frame_err_q <= 1'b1;
            end
            shreg_q   <= '0;
            bit_cnt_q <= '0;
            state_q   <= cs_fall ? StShift : StIdle;
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign dac_a     = dac_a_q;
  assign dac_b     = dac_b_q;
  assign in_a      = in_a_q;
  assign in_b      = in_b_q;
  assign update    = update_q;
  assign upd_chan  = upd_chan_q;
  assign frame_err = frame_err_q;
  assign frame_cnt = frame_cnt_q;

endmodule
